// File: rtl/hamming_decode.sv
// Serial Hamming(7,4) decoder: collects p1 p2 d1 p4 d2 d3 d4, reports syndrome and error count.
// Define HAMMING_DECODE_CORRECT_EN to correct the single-bit error before extracting data.
`timescale 1ns/1ps
module hamming_decode #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in,
   input  logic             in_vld,
   input  logic             in_sof,
   output logic [3:0]       out,
   output logic             out_vld,
   output logic             err_corr,
   output logic [2:0]       syndrome,
   output logic             err_frame,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic [0:0] {StIdle, StCollect} state_e;

   state_e           state_q, state_d;
   logic [2:0]       bcnt_q, bcnt_d;
   // sreg_q[i] holds codeword position i+1
   logic [6:0]       sreg_q, sreg_d;
   logic [3:0]       out_q;
   logic             out_vld_q;
   logic             err_corr_q;
   logic [2:0]       syndrome_q;
   logic             err_frame_q;
   logic [CNT_W-1:0] err_cnt_q;

   logic             done;
   logic             abort;
   logic [6:0]       word;
   logic [6:0]       fixed;
   logic [2:0]       syn;
   logic [3:0]       data;

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      sreg_d  = sreg_q;
      done    = 1'b0;
      abort   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_vld && in_sof) begin
               sreg_d  = {6'b0, in};
               bcnt_d  = 3'd1;
               state_d = StCollect;
            end
         end
         StCollect: begin
            if (in_vld) begin
               if (in_sof) begin
                  abort  = 1'b1;
                  sreg_d = {6'b0, in};
                  bcnt_d = 3'd1;
               end else if (bcnt_q == 3'd6) begin
                  done      = 1'b1;
                  sreg_d[6] = in;
                  bcnt_d    = 3'd0;
                  state_d   = StIdle;
               end else begin
                  sreg_d[bcnt_q] = in;
                  bcnt_d         = bcnt_q + 3'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Bit 7 is decoded straight off the input so the result registers on its accepting edge.
   always_comb begin
      word   = {in, sreg_q[5:0]};
      syn[0] = word[0] ^ word[2] ^ word[4] ^ word[6];
      syn[1] = word[1] ^ word[2] ^ word[5] ^ word[6];
      syn[2] = word[3] ^ word[4] ^ word[5] ^ word[6];
      fixed  = word;
`ifdef HAMMING_DECODE_CORRECT_EN
      if (syn != 3'd0) begin
         fixed[syn - 3'd1] = ~word[syn - 3'd1];
      end
`endif
      data = {fixed[2], fixed[4], fixed[5], fixed[6]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bcnt_q      <= 3'd0;
         sreg_q      <= 7'd0;
         out_q       <= 4'd0;
         out_vld_q   <= 1'b0;
         err_corr_q  <= 1'b0;
         syndrome_q  <= 3'd0;
         err_frame_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         bcnt_q      <= bcnt_d;
         sreg_q      <= sreg_d;
         out_vld_q   <= done;
         err_frame_q <= abort;
         if (done) begin
            out_q      <= data;
            syndrome_q <= syn;
            err_corr_q <= (syn != 3'd0);
            if ((syn != 3'd0) && (err_cnt_q != {CNT_W{1'b1}})) begin
               err_cnt_q <= err_cnt_q + 1'b1;
            end
         end
      end
   end

   assign out       = out_q;
   assign out_vld   = out_vld_q;
   assign err_corr  = err_corr_q;
   assign syndrome  = syndrome_q;
   assign err_frame = err_frame_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_hamming_decode.sv
// Bench for hamming_decode: directed scenarios plus random codewords against an encode/flip model.
`timescale 1ns/1ps
module tb_hamming_decode;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       din = 1'b0;
   logic       vld = 1'b0;
   logic       sof = 1'b0;
   logic [3:0] out, out_2;
   logic       out_vld, out_vld_2;
   logic       err_corr, err_corr_2;
   logic [2:0] syndrome, syndrome_2;
   logic       err_frame, err_frame_2;
   logic [7:0] err_cnt;
   logic [1:0] err_cnt_2;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   typedef struct {
      logic [3:0] d;
      logic [2:0] s;
      logic       c;
      logic [7:0] n8;
      logic [1:0] n2;
      logic [3:0] d2;
      logic [2:0] s2;
      logic       c2;
      logic       v2;
      int         t;
   } rec_t;

   rec_t got_q[$];
   rec_t exp_q[$];
   int   frm_got_q[$];
   int   frm_exp_q[$];
   logic frm2_q[$];

   int   m8 = 0;
   int   m2 = 0;
   bit   in_collect = 0;

   hamming_decode #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in(din), .in_vld(vld), .in_sof(sof),
      .out(out), .out_vld(out_vld), .err_corr(err_corr), .syndrome(syndrome),
      .err_frame(err_frame), .err_cnt(err_cnt)
   );

   hamming_decode #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in(din), .in_vld(vld), .in_sof(sof),
      .out(out_2), .out_vld(out_vld_2), .err_corr(err_corr_2), .syndrome(syndrome_2),
      .err_frame(err_frame_2), .err_cnt(err_cnt_2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      rec_t r;
      if (out_vld) begin
         r.d  = out;
         r.s  = syndrome;
         r.c  = err_corr;
         r.n8 = err_cnt;
         r.n2 = err_cnt_2;
         r.d2 = out_2;
         r.s2 = syndrome_2;
         r.c2 = err_corr_2;
         r.v2 = out_vld_2;
         r.t  = cyc;
         got_q.push_back(r);
      end
      if (err_frame) begin
         frm_got_q.push_back(cyc);
         frm2_q.push_back(err_frame_2);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] encode(input logic [3:0] d);
      logic d1, d2, d3, d4;
      logic [6:0] cw;
      {d1, d2, d3, d4} = d;
      cw[0] = d1 ^ d2 ^ d4;
      cw[1] = d1 ^ d3 ^ d4;
      cw[2] = d1;
      cw[3] = d2 ^ d3 ^ d4;
      cw[4] = d2;
      cw[5] = d3;
      cw[6] = d4;
      return cw;
   endfunction

   task automatic drive(input logic b, input logic v, input logic s);
      @(negedge clk);
      din = b;
      vld = v;
      sof = s;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_partial(input int k);
      logic [6:0] cw;
      cw = encode(4'($urandom_range(0, 15)));
      for (int i = 0; i < k; i++) begin
         drive(cw[i], 1'b1, i == 0);
         if (i == 0 && in_collect) frm_exp_q.push_back(cyc + 1);
      end
      in_collect = 1;
   endtask

   task automatic send_word(input logic [3:0] d, input int flip, input int gap);
      logic [6:0] cw;
      rec_t e;
      cw = encode(d);
      if (flip != 0) cw[flip-1] = ~cw[flip-1];
      for (int i = 0; i < 7; i++) begin
         drive(cw[i], 1'b1, i == 0);
         if (i == 0 && in_collect) frm_exp_q.push_back(cyc + 1);
         if (i == 6) e.t = cyc + 1;
         if (i < 6) idle(gap);
      end
      in_collect = 0;
`ifdef HAMMING_DECODE_CORRECT_EN
      e.d = d;
`else
      e.d = {cw[2], cw[4], cw[5], cw[6]};
`endif
      e.s = 3'(flip);
      e.c = (flip != 0);
      if (flip != 0) begin
         if (m8 < 255) m8++;
         if (m2 < 3) m2++;
      end
      e.n8 = 8'(m8);
      e.n2 = 2'(m2);
      e.d2 = e.d;
      e.s2 = e.s;
      e.c2 = e.c;
      e.v2 = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic check_all(input string tag);
      rec_t g, e;
      chk({tag, ".vld_count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, ".out"}, g.d, e.d);
         chk({tag, ".syndrome"}, g.s, e.s);
         chk({tag, ".err_corr"}, g.c, e.c);
         chk({tag, ".err_cnt"}, g.n8, e.n8);
         chk({tag, ".err_cnt_w2"}, g.n2, e.n2);
         chk({tag, ".latency_cyc"}, g.t, e.t);
         chk({tag, ".w2_out"}, {g.v2, g.c2, g.s2, g.d2}, {e.v2, e.c2, e.s2, e.d2});
      end
      got_q.delete();
      exp_q.delete();
      chk({tag, ".frame_count"}, frm_got_q.size(), frm_exp_q.size());
      while (frm_got_q.size() > 0 && frm_exp_q.size() > 0) begin
         chk({tag, ".frame_cyc"}, frm_got_q.pop_front(), frm_exp_q.pop_front());
         chk({tag, ".frame_w2"}, frm2_q.pop_front(), 1'b1);
      end
      frm_got_q.delete();
      frm_exp_q.delete();
      frm2_q.delete();
   endtask

   initial begin
      // reset state
      idle(3);
      #1;
      chk("rst.outs", {out, out_vld, err_corr, syndrome, err_frame}, 32'd0);
      chk("rst.err_cnt", {err_cnt, err_cnt_2}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // clean word 1011 -> 0110011
      send_word(4'b1011, 0, 0);
      idle(3);
      check_all("clean");
      chk("hold.out", {out, syndrome, err_corr, out_vld}, {4'b1011, 3'd0, 1'b0, 1'b0});

      // position 5 flipped
      send_word(4'b1011, 5, 0);
      idle(2);
      check_all("flip5");
`ifdef HAMMING_DECODE_CORRECT_EN
      chk("flip5.final_out", out, 4'b1011);
`else
      chk("flip5.final_out", out, 4'b1111);
`endif

      // stray in_vld without in_sof in idle is ignored
      for (int i = 0; i < 9; i++) drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      idle(3);
      check_all("stray");

      // 3-bit partial aborted by a fresh 0000000 word
      send_partial(3);
      send_word(4'b0000, 0, 0);
      idle(3);
      check_all("abort");

      // gapped word then back-to-back zero word
      send_word(4'b1011, 0, 2);
      send_word(4'b0000, 0, 0);
      idle(3);
      check_all("gaps");

      // reset after bit 4
      send_partial(4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst.outs", {out, out_vld, err_corr, syndrome, err_frame}, 32'd0);
      chk("midrst.err_cnt", {err_cnt, err_cnt_2}, 32'd0);
      vld = 1'b0;
      sof = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m8 = 0;
      m2 = 0;
      in_collect = 0;
      idle(3);
      check_all("midrst_quiet");
      send_word(4'b1011, 0, 0);
      idle(3);
      check_all("midrst");

      // five single-bit errors back to back: narrow counter saturates
      for (int i = 1; i <= 5; i++) send_word(4'($urandom_range(0, 15)), i, 0);
      idle(3);
      check_all("sat");

      // random traffic
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 5) == 0) send_partial($urandom_range(1, 6));
         if (!in_collect && $urandom_range(0, 7) == 0) begin
            drive(1'($urandom_range(0, 1)), 1'b1, 1'b0);
         end
         send_word(4'($urandom_range(0, 15)), $urandom_range(0, 7), $urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(3);
      check_all("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
